// File: rtl/multicycle_cpu_if.sv
// Instruction and data memory bus between the core (master) and its memories (slave).
interface multicycle_cpu_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic [31:0]     dmem_addr;
   logic [31:0]     dmem_wdata;
   logic            dmem_ready;
   logic [31:0]     dmem_rdata;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I subset core: FETCH -> EXEC (-> MEM) -> FETCH, word-addressed pc,
// stops in HALT when pc reaches HALT_PC. Anything it does not decode runs as a NOP.
module multicycle_cpu #(
   parameter int              PC_W    = 8,
   parameter logic [PC_W-1:0] HALT_PC = {PC_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   multicycle_cpu_if.master bus,
   output logic [PC_W-1:0]  pc,
   output logic             halted
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t          state, state_next;
   logic [31:0]     ir;
   logic [31:0]     regs [32];
   logic [PC_W-1:0] pc_next, pc_plus1, br_target, j_target;

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic [31:0] rs1_val, rs2_val, alu_b, alu_result, link, rf_wdata;
   logic        is_alu_r, is_alu_i, is_lui, is_lw, is_sw, is_branch, is_jal;
   logic        r_legal, i_legal, br_taken, rf_we, ir_load;
   logic        imem_req, dmem_req, dmem_we;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign imm_u = {ir[31:12], 12'b0};

   // Only SUB/SRA (and SRAI) may carry funct7 = 0100000; other funct7 patterns are illegal.
   assign r_legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
   assign i_legal = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                    (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1;

   assign is_alu_r  = (opcode == OP_R) && r_legal;
   assign is_alu_i  = (opcode == OP_I) && i_legal;
   assign is_lui    = (opcode == OP_LUI);
   assign is_lw     = (opcode == OP_LOAD) && (funct3 == 3'b010);
   assign is_sw     = (opcode == OP_STORE) && (funct3 == 3'b010);
   assign is_branch = (opcode == OP_BRANCH) &&
                      (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101);
   assign is_jal    = (opcode == OP_JAL);

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
   assign alu_b   = is_alu_r ? rs2_val : imm_i;

   assign pc_plus1  = pc + PC_W'(1);
   assign br_target = pc + PC_W'($signed(imm_b) >>> 2);
   assign j_target  = pc + PC_W'($signed(imm_j) >>> 2);
   assign link      = 32'({pc_plus1, 2'b00});

   // ALU shared by register and immediate forms; funct7[5] picks SUB (R only) or SRA.
   always_comb begin
      alu_result = 32'd0;
      case (funct3)
         3'b000:  alu_result = (is_alu_r && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001:  alu_result = rs1_val << alu_b[4:0];
         3'b010:  alu_result = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         3'b011:  alu_result = {31'd0, rs1_val < alu_b};
         3'b100:  alu_result = rs1_val ^ alu_b;
         3'b101:  alu_result = funct7[5] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
         3'b110:  alu_result = rs1_val | alu_b;
         default: alu_result = rs1_val & alu_b;
      endcase
   end

   // Branch condition from the two register operands.
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
         3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         default: br_taken = 1'b0;
      endcase
   end

   // Next state, pc, register write-back and bus requests; reset silences all requests.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      rf_we      = 1'b0;
      rf_wdata   = alu_result;
      ir_load    = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      case (state)
         FETCH: begin
            if (pc == HALT_PC) begin
               state_next = HALT;
            end else begin
               imem_req = 1'b1;
               if (bus.imem_ready) begin
                  ir_load    = 1'b1;
                  state_next = EXEC;
               end
            end
         end
         EXEC: begin
            state_next = FETCH;
            pc_next    = pc_plus1;
            if (is_lw || is_sw) begin
               state_next = MEM;
               pc_next    = pc;
            end else if (is_alu_r || is_alu_i) begin
               rf_we = 1'b1;
            end else if (is_lui) begin
               rf_we    = 1'b1;
               rf_wdata = imm_u;
            end else if (is_branch) begin
               if (br_taken) pc_next = br_target;
            end else if (is_jal) begin
               rf_we    = 1'b1;
               rf_wdata = link;
               pc_next  = j_target;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (bus.dmem_ready) begin
               rf_we      = is_lw;
               rf_wdata   = bus.dmem_rdata;
               pc_next    = pc_plus1;
               state_next = FETCH;
            end
         end
         default: begin
            state_next = HALT;
         end
      endcase
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
      end
   end

   // State, pc and instruction register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (ir_load) ir <= bus.imem_rdata;
      end
   end

   // Register file: x0 is never written, everything clears on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (rf_we && rd != 5'd0) begin
         regs[rd] <= rf_wdata;
      end
   end

   assign bus.imem_req   = imem_req;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = dmem_req;
   assign bus.dmem_we    = dmem_we;
   assign bus.dmem_addr  = rs1_val + (is_sw ? imm_s : imm_i);
   assign bus.dmem_wdata = rs2_val;
   assign halted         = (state == HALT);
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: small programs in a bench-side instruction memory,
// a data memory with programmable wait states and a store log, plus a PC_W=4 core for HALT.
module tb_multicycle_cpu;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst4 = 1'b1;
   logic [7:0] pc;
   logic       halted;
   logic [3:0] pc4;
   logic       halted4;

   int total = 0;
   int bad = 0;
   int dmem_wait = 0;
   int wait_cnt = 0;
   int st_count = 0;

   logic [31:0] imem_mem [256];
   logic [31:0] dmem_mem [256];
   logic [31:0] st_addr [16];
   logic [31:0] st_data [16];

   multicycle_cpu_if #(.PC_W(8)) bus ();
   multicycle_cpu_if #(.PC_W(4)) bus4 ();

   multicycle_cpu #(.PC_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .pc(pc), .halted(halted)
   );

   multicycle_cpu #(.PC_W(4), .HALT_PC(4'hF)) dut4 (
      .clk(clk), .rst(rst4), .bus(bus4), .pc(pc4), .halted(halted4)
   );

   always #5 clk = ~clk;

   assign bus.imem_ready  = 1'b1;
   assign bus.imem_rdata  = imem_mem[bus.imem_addr];
   assign bus.dmem_ready  = bus.dmem_req && (wait_cnt == dmem_wait);
   assign bus.dmem_rdata  = dmem_mem[bus.dmem_addr[9:2]];

   assign bus4.imem_ready = 1'b1;
   assign bus4.imem_rdata = 32'h00108093;
   assign bus4.dmem_ready = 1'b0;
   assign bus4.dmem_rdata = 32'd0;

   // Counts wait cycles of the current data access.
   always @(posedge clk) begin
      if (bus.dmem_req && !bus.dmem_ready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   // Data memory writes and a log of accepted stores, cleared while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         st_count <= 0;
      end else if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
         dmem_mem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
         if (st_count < 16) begin
            st_addr[st_count] <= bus.dmem_addr;
            st_data[st_count] <= bus.dmem_wdata;
         end
         st_count <= st_count + 1;
      end
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem_mem[i] = 32'h00000013;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   task automatic load_main();
      clear_imem();
      imem_mem[0] = addi(5'd1, 5'd0, 12'd5);
      imem_mem[1] = addi(5'd2, 5'd0, 12'hFFD);
      imem_mem[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
      imem_mem[3] = enc_sw(12'd8, 5'd3, 5'd0);
      imem_mem[4] = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
      imem_mem[5] = enc_sw(12'd12, 5'd4, 5'd0);
      imem_mem[6] = enc_j(21'd0, 5'd0);
   endtask

   task automatic test_reset();
      load_main();
      rst = 1'b1;
      run(2);
      total++; if (pc !== 8'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d exp=0", pc); end
      total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_imem_req got=%b exp=0", bus.imem_req); end
      total++; if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_dmem got=%b%b exp=00", bus.dmem_req, bus.dmem_we);
      end
      rst = 1'b0;
      #1;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin
         bad++; $display("[TB] FAIL first_fetch got req=%b addr=%0d exp req=1 addr=0", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_alu_sequence();
      dmem_wait = 0;
      load_main();
      reset_dut();
      run(5);
      total++; if (pc !== 8'd2) begin bad++; $display("[TB] FAIL alu_pc_c5 got=%0d exp=2", pc); end
      run(1);
      total++; if (pc !== 8'd3) begin bad++; $display("[TB] FAIL alu_pc_c6 got=%0d exp=3", pc); end
   endtask

   task automatic test_load_store();
      dmem_wait = 2;
      load_main();
      reset_dut();
      run(8);
      total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
         bad++; $display("[TB] FAIL sw_req got req=%b we=%b exp 1 1", bus.dmem_req, bus.dmem_we);
      end
      total++; if (bus.dmem_addr !== 32'd8 || bus.dmem_wdata !== 32'd2) begin
         bad++; $display("[TB] FAIL sw_addr_data got=%0d/%0d exp=8/2", bus.dmem_addr, bus.dmem_wdata);
      end
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL sw_no_imem got=%b exp=0", bus.imem_req); end
      run(2);
      total++; if (pc !== 8'd3 || bus.dmem_req !== 1'b1) begin
         bad++; $display("[TB] FAIL sw_wait got pc=%0d req=%b exp pc=3 req=1", pc, bus.dmem_req);
      end
      run(1);
      total++; if (pc !== 8'd4) begin bad++; $display("[TB] FAIL sw_done_pc got=%0d exp=4", pc); end
      run(2);
      total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'd8) begin
         bad++; $display("[TB] FAIL lw_req got req=%b we=%b addr=%0d exp 1 0 8", bus.dmem_req, bus.dmem_we, bus.dmem_addr);
      end
      run(3);
      total++; if (pc !== 8'd5) begin bad++; $display("[TB] FAIL lw_done_pc got=%0d exp=5", pc); end
      run(2);
      total++; if (bus.dmem_addr !== 32'd12 || bus.dmem_wdata !== 32'd2) begin
         bad++; $display("[TB] FAIL lw_value got addr=%0d data=%0d exp 12 2", bus.dmem_addr, bus.dmem_wdata);
      end
   endtask

   task automatic test_alu_ops();
      logic [31:0] exp_data [10];
      exp_data[0] = 32'd8;         exp_data[1] = 32'd1;
      exp_data[2] = 32'd0;         exp_data[3] = 32'hFFFFFFFF;
      exp_data[4] = 32'h07FFFFFF;  exp_data[5] = 32'd40;
      exp_data[6] = 32'hFFFFFFFA;  exp_data[7] = 32'h12345000;
      exp_data[8] = 32'h000000F0;  exp_data[9] = 32'hFFFFFFFE;
      dmem_wait = 0;
      clear_imem();
      imem_mem[0]  = addi(5'd1, 5'd0, 12'd5);
      imem_mem[1]  = addi(5'd2, 5'd0, 12'hFFD);
      imem_mem[2]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd6);
      imem_mem[3]  = enc_r(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd7);
      imem_mem[4]  = enc_r(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd8);
      imem_mem[5]  = enc_r(7'b0100000, 5'd1, 5'd2, 3'b101, 5'd9);
      imem_mem[6]  = enc_r(7'b0000000, 5'd1, 5'd2, 3'b101, 5'd10);
      imem_mem[7]  = enc_i(12'h003, 5'd1, 3'b001, 5'd11, 7'b0010011);
      imem_mem[8]  = enc_i(12'hFFF, 5'd1, 3'b100, 5'd12, 7'b0010011);
      imem_mem[9]  = {20'h12345, 5'd13, 7'b0110111};
      imem_mem[10] = enc_i(12'h0F0, 5'd2, 3'b111, 5'd14, 7'b0010011);
      imem_mem[11] = enc_i(12'h401, 5'd2, 3'b101, 5'd15, 7'b0010011);
      for (int k = 0; k < 10; k++) imem_mem[12 + k] = enc_sw(12'(64 + 4 * k), 5'(6 + k), 5'd0);
      imem_mem[22] = enc_j(21'd0, 5'd0);
      reset_dut();
      run(60);
      total++; if (st_count !== 10) begin bad++; $display("[TB] FAIL ops_store_count got=%0d exp=10", st_count); end
      for (int k = 0; k < 10; k++) begin
         total++;
         if (st_addr[k] !== 32'(64 + 4 * k) || st_data[k] !== exp_data[k]) begin
            bad++;
            $display("[TB] FAIL ops_result%0d got addr=%0d data=%h exp addr=%0d data=%h",
                     k, st_addr[k], st_data[k], 64 + 4 * k, exp_data[k]);
         end
      end
   endtask

   task automatic test_branches();
      dmem_wait = 0;
      clear_imem();
      imem_mem[0] = addi(5'd1, 5'd0, 12'd5);
      imem_mem[1] = addi(5'd2, 5'd0, 12'hFFD);
      imem_mem[2] = enc_j(21'd8, 5'd0);
      imem_mem[4] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
      imem_mem[5] = enc_j(21'd8, 5'd7);
      imem_mem[6] = enc_b(13'h1FFC, 5'd1, 5'd2, 3'b100);
      imem_mem[7] = enc_sw(12'd0, 5'd7, 5'd0);
      imem_mem[8] = enc_j(21'd0, 5'd0);
      reset_dut();
      run(6);
      total++; if (pc !== 8'd4) begin bad++; $display("[TB] FAIL jal_fwd_pc got=%0d exp=4", pc); end
      run(2);
      total++; if (pc !== 8'd6) begin bad++; $display("[TB] FAIL beq_taken_pc got=%0d exp=6", pc); end
      run(2);
      total++; if (pc !== 8'd5) begin bad++; $display("[TB] FAIL blt_back_pc got=%0d exp=5", pc); end
      run(2);
      total++; if (pc !== 8'd7) begin bad++; $display("[TB] FAIL jal_link_pc got=%0d exp=7", pc); end
      run(3);
      total++; if (st_count !== 1 || st_addr[0] !== 32'd0 || st_data[0] !== 32'd24) begin
         bad++; $display("[TB] FAIL jal_link_val got n=%0d addr=%0d data=%0d exp 1 0 24", st_count, st_addr[0], st_data[0]);
      end
      imem_mem[4] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
      imem_mem[5] = enc_b(13'd8, 5'd1, 5'd2, 3'b101);
      reset_dut();
      run(8);
      total++; if (pc !== 8'd5) begin bad++; $display("[TB] FAIL bne_not_taken_pc got=%0d exp=5", pc); end
      run(2);
      total++; if (pc !== 8'd6) begin bad++; $display("[TB] FAIL bge_not_taken_pc got=%0d exp=6", pc); end
      run(2);
      total++; if (pc !== 8'd5) begin bad++; $display("[TB] FAIL blt_again_pc got=%0d exp=5", pc); end
   endtask

   task automatic test_x0_and_illegal();
      dmem_wait = 0;
      clear_imem();
      imem_mem[0] = addi(5'd0, 5'd0, 12'd7);
      imem_mem[1] = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd5);
      imem_mem[2] = 32'h0000007F;
      imem_mem[3] = 32'h000002FF;
      imem_mem[4] = enc_sw(12'd16, 5'd5, 5'd0);
      imem_mem[5] = enc_j(21'd0, 5'd0);
      reset_dut();
      run(5);
      total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL illegal_no_dmem got=%b exp=0", bus.dmem_req); end
      run(1);
      total++; if (pc !== 8'd3) begin bad++; $display("[TB] FAIL illegal_pc got=%0d exp=3", pc); end
      run(4);
      total++; if (pc !== 8'd4 || bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'd16 || bus.dmem_wdata !== 32'd0) begin
         bad++; $display("[TB] FAIL x0_value got pc=%0d req=%b addr=%0d data=%0d exp 4 1 16 0",
                         pc, bus.dmem_req, bus.dmem_addr, bus.dmem_wdata);
      end
   endtask

   task automatic test_reset_mid_access();
      dmem_wait = 5;
      load_main();
      reset_dut();
      run(8);
      total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_req got=%b exp=1", bus.dmem_req); end
      rst = 1'b1;
      clear_imem();
      imem_mem[0] = enc_sw(12'd24, 5'd3, 5'd0);
      imem_mem[1] = enc_sw(12'd28, 5'd1, 5'd0);
      imem_mem[2] = enc_j(21'd0, 5'd0);
      run(1);
      total++; if (bus.dmem_req !== 1'b0 || pc !== 8'd0 || bus.imem_req !== 1'b0) begin
         bad++; $display("[TB] FAIL mid_reset got dreq=%b pc=%0d ireq=%b exp 0 0 0", bus.dmem_req, pc, bus.imem_req);
      end
      dmem_wait = 0;
      rst = 1'b0;
      #1;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin
         bad++; $display("[TB] FAIL mid_resume got req=%b addr=%0d exp 1 0", bus.imem_req, bus.imem_addr);
      end
      run(6);
      total++; if (st_count !== 2 || st_addr[0] !== 32'd24 || st_data[0] !== 32'd0 || st_data[1] !== 32'd0) begin
         bad++; $display("[TB] FAIL mid_regs_cleared got n=%0d addr0=%0d d0=%0d d1=%0d exp 2 24 0 0",
                         st_count, st_addr[0], st_data[0], st_data[1]);
      end
   endtask

   task automatic test_halt();
      total++; if (pc4 !== 4'd0 || halted4 !== 1'b0) begin
         bad++; $display("[TB] FAIL halt_reset got pc=%0d halted=%b exp 0 0", pc4, halted4);
      end
      @(negedge clk);
      rst4 = 1'b0;
      run(30);
      total++; if (pc4 !== 4'd15 || bus4.imem_req !== 1'b0 || halted4 !== 1'b0) begin
         bad++; $display("[TB] FAIL halt_reach got pc=%0d req=%b halted=%b exp 15 0 0", pc4, bus4.imem_req, halted4);
      end
      run(1);
      total++; if (halted4 !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag got=%b exp=1", halted4); end
      for (int k = 0; k < 5; k++) begin
         run(1);
         total++;
         if (bus4.imem_req !== 1'b0 || halted4 !== 1'b1 || pc4 !== 4'd15) begin
            bad++; $display("[TB] FAIL halt_hold%0d got req=%b halted=%b pc=%0d exp 0 1 15", k, bus4.imem_req, halted4, pc4);
         end
      end
   endtask

   initial begin
      $display("[TB] multicycle_cpu directed tests");
      test_reset();
      test_alu_sequence();
      test_load_store();
      test_alu_ops();
      test_branches();
      test_x0_and_illegal();
      test_reset_mid_access();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter PC_W, default 8, word-address width of pc and imem_addr (min 2, max 30).
REQ-002 SHALL have parameter HALT_PC, default all-ones of PC_W, pc value at which execution stops.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  PC_W  word address of the fetch; always equals pc.
REQ-008 imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  fetched RV32I instruction.
REQ-010 dmem_req  output  1  data memory request.
REQ-011 dmem_we  output  1  1 = store, 0 = load; valid only while dmem_req=1.
REQ-012 dmem_addr  output  32  byte address, rs1 + sign-extended immediate.
REQ-013 dmem_wdata  output  32  store data (rs2).
REQ-014 dmem_ready  input  1  data access complete; dmem_rdata valid for loads.
REQ-015 dmem_rdata  input  32  load data.
REQ-016 pc  output  PC_W  current instruction word address.
REQ-017 halted  output  1  1 while in HALT state.

Function
REQ-018 SHALL implement FSM states FETCH, EXEC, MEM, HALT.
REQ-019 FETCH: if pc == HALT_PC, go to HALT without requesting; else imem_req=1 held until imem_ready=1, then latch imem_rdata into the instruction register and go to EXEC.
REQ-020 EXEC: decode, read rs1/rs2, compute ALU result; LW/SW go to MEM; all other instructions write back and update pc at the end of the EXEC cycle, then go to FETCH.
REQ-021 MEM: dmem_req=1, dmem_we per opcode, dmem_addr/dmem_wdata stable until dmem_ready=1; on ready, LW writes dmem_rdata to rd, pc <= pc+1, go to FETCH.
REQ-022 Supported: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; the I-type forms of each (no SUBI); LUI, LW, SW, BEQ, BNE, BLT, BGE, JAL.
REQ-023 Shift amount SHALL be operand[4:0]; all arithmetic 32-bit modulo 2^32.
REQ-024 Branch taken: pc <= pc + (B-immediate >>> 2) truncated to PC_W; not taken: pc <= pc+1.
REQ-025 JAL: rd <= zero-extended {pc+1, 2'b00}; pc <= pc + (J-immediate >>> 2) truncated to PC_W.
REQ-026 pc arithmetic SHALL wrap modulo 2^PC_W.
REQ-027 Unsupported or illegal opcodes SHALL execute as NOP (pc+1, no writes, no dmem_req).
REQ-028 Register file: 32x32, two asynchronous read ports, one write port; x0 reads 0 and ignores writes.
REQ-029 Latency with zero-wait memories: 2 cycles per non-memory instruction, 3 cycles per LW/SW; each wait cycle adds one.
REQ-030 imem_req and dmem_req SHALL never be high in the same cycle.
REQ-031 HALT: no requests, pc frozen, halted=1, until reset.
REQ-032 A ready input arriving while the core is not requesting SHALL be ignored.

Reset
REQ-033 rst=1 SHALL set state FETCH, pc=0, halted=0, imem_req=0, dmem_req=0, dmem_we=0, and all registers x1..x31 to 0.
REQ-034 rst asserted mid-fetch or mid-access SHALL deassert requests in the following cycle and discard the pending instruction, with no register or pc update from it.
REQ-035 The first fetch SHALL occur in the cycle after rst deasserts.

Verification
REQ-036 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 (zero-wait) -> x3=2, pc=3 after 6 cycles.
REQ-037 SW x3,8(x0) then LW x4,8(x0), dmem_ready delayed 2 cycles -> dmem_addr=8, dmem_wdata=2, x4=2; each access takes 5 cycles.
REQ-038 BEQ x1,x1,+8 at pc=4 -> pc=6; BNE x1,x1,+8 at pc=4 -> pc=5; BLT x2,x1,-4 at pc=6 (x2=-3 < x1=5) -> pc=5.
REQ-039 PC_W=4, straight-line ADDIs -> halted=1 when pc reaches 15, no imem_req afterwards.
REQ-040 rst pulsed while dmem_req=1 -> dmem_req=0 next cycle, pc=0, registers 0, fetch resumes after release.
REQ-041 ADDI x0,x0,7 then ADD x5,x0,x0 -> x5=0; illegal opcode 0x0000007F -> pc+1, no state change.
